// File: rtl/multi_comparator.sv
// Multi-channel programmable masked comparator.
// Per-channel value/mask/enable, registered match, sticky flags and hit counter.
module multi_comparator #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 2,
  parameter int COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_sel,
  input  logic [1:0]          cfg_reg,
  input  logic [WIDTH-1:0]    cfg_data,
  input  logic [WIDTH-1:0]    data,
  input  logic                valid,
  input  logic [CHANNELS-1:0] clr_sticky,
  input  logic                clr_count,
  output logic [CHANNELS-1:0] equal,
  output logic                hit,
  output logic [IDX_W-1:0]    hit_idx,
  output logic [CHANNELS-1:0] sticky,
  output logic [COUNT_W-1:0]  hit_count
);

  localparam logic [1:0] REG_VAL  = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_EN   = 2'd2;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]    r_val  [CHANNELS];
  logic [WIDTH-1:0]    r_mask [CHANNELS];
  logic [CHANNELS-1:0] r_en;

  logic [CHANNELS-1:0] r_equal;
  logic                r_hit;
  logic [IDX_W-1:0]    r_hit_idx;
  logic [CHANNELS-1:0] r_sticky;
  logic [COUNT_W-1:0]  r_count;

  logic [CHANNELS-1:0] w_match;
  logic                w_any;
  logic [IDX_W-1:0]    w_idx;

  // Per-channel masked compare against the current (pre-write) config
  always_comb begin
    w_match = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_match[i] = r_en[i] & valid &
                   (((data ^ r_val[i]) & r_mask[i]) == '0);
    end
  end

  assign w_any = |w_match;

  // Lowest-index priority encode; scan downward so the lowest wins
  always_comb begin
    w_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_match[i]) w_idx = IDX_W'(i);
    end
  end

  // Config register file; selects beyond CHANNELS never match the loop
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_val[i]  <= '0;
        r_mask[i] <= '1;
      end
      r_en <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_sel == IDX_W'(i)) begin
          case (cfg_reg)
            REG_VAL:  r_val[i]  <= cfg_data;
            REG_MASK: r_mask[i] <= cfg_data;
            REG_EN:   r_en[i]   <= cfg_data[0];
            default:  ;
          endcase
        end
      end
    end
  end

  // Registered match outputs; not held when valid drops
  always_ff @(posedge clk) begin
    if (reset) begin
      r_equal   <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_equal   <= w_match;
      r_hit     <= w_any;
      r_hit_idx <= w_idx;
    end
  end

  // Sticky history; a new match beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) r_sticky <= '0;
    else       r_sticky <= (r_sticky & ~clr_sticky) | w_match;
  end

  // Saturating hit counter; clear then count in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr_count) begin
      r_count <= w_any ? COUNT_W'(1) : '0;
    end else if (w_any && r_count != CNT_MAX) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end

  assign equal     = r_equal;
  assign hit       = r_hit;
  assign hit_idx   = r_hit_idx;
  assign sticky    = r_sticky;
  assign hit_count = r_count;

endmodule
